ysyx_201979054_cache_xfer_ctrl: RTL and testbench

Sequencing and arbitration controller for the shared cache block-transfer datapath (counter + address incrementer + block FIFO). Accepts block refill requests from the I-cache and refill/writeback requests from the D-cache, and grants the datapath to one requester at a time with round-robin fairness. For a dirty D-cache victim it runs writeback before refill. It generates the one-cycle start pulses, the aligned base address and AXI run levels, and ends each transaction with a done/error response.

---
 rtl/ysyx_201979054_cache_pkg.sv | 22 ++
 rtl/ysyx_201979054_rr_arbiter.sv | 37 +++
 rtl/ysyx_201979054_cache_xfer_ctrl.sv | 140 ++++++++++++++
 tb/tb_ysyx_201979054_cache_xfer_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_201979054_cache_pkg.sv
// Shared types and defaults for the cache block-transfer controller.
// Both the top-level sequencer and the round-robin arbiter import this package.
package ysyx_201979054_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_START,
        WB_RUN,
        RF_START,
        RF_RUN,
        RESP
    } t_xfer_state;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } t_req_id;

    localparam int DEF_OFFSET_BITS = 6;
    localparam int DEF_TIMEOUT     = 1024;

endpackage

// File: rtl/ysyx_201979054_rr_arbiter.sv
// Two-way round-robin arbiter: a tie goes to the requester that was not served last.
// The history only advances when a transaction completes, not when a grant is first issued.
module ysyx_201979054_rr_arbiter
    import ysyx_201979054_cache_pkg::*;
(
    input  logic    clk,
    input  logic    arst,
    input  logic    req_i,
    input  logic    req_d,
    input  logic    grant_done,
    input  t_req_id done_id,
    output logic    grant_valid,
    output t_req_id grant_id
);

    t_req_id last_grant;

    // Reset to D so that the I-cache wins the very first tie.
    always_ff @(posedge clk) begin
        if (arst) begin
            last_grant <= REQ_D;
        end else if (grant_done) begin
            last_grant <= done_id;
        end
    end

    always_comb begin
        grant_valid = req_i | req_d;
        grant_id    = REQ_I;
        if (req_i && req_d) begin
            grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/ysyx_201979054_cache_xfer_ctrl.sv
// Sequencer for the shared cache block-transfer datapath: arbitrates I/D requests,
// runs an optional writeback before the refill, and closes every transaction with done/error.
module ysyx_201979054_cache_xfer_ctrl
    import ysyx_201979054_cache_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int OFFSET_BITS    = DEF_OFFSET_BITS,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      i_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] i_addr_i,
    input  logic                      i_req_d,
    input  logic                      i_dirty_d,
    input  logic [AXI_ADDR_WIDTH-1:0] i_addr_d,
    input  logic [AXI_ADDR_WIDTH-1:0] i_wb_addr_d,
    input  logic                      i_count_done,
    input  logic                      i_axi_error,
    output logic                      o_start_read,
    output logic                      o_start_write,
    output logic                      o_rd_active,
    output logic                      o_wr_active,
    output logic [AXI_ADDR_WIDTH-1:0] o_addr_cache,
    output logic                      o_grant_i,
    output logic                      o_grant_d,
    output logic                      o_done_i,
    output logic                      o_done_d,
    output logic                      o_error,
    output logic                      o_busy
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = {AXI_ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    t_xfer_state               state;
    t_xfer_state               next_state;
    t_req_id                   owner;
    logic [AXI_ADDR_WIDTH-1:0] rf_addr;
    logic [AXI_ADDR_WIDTH-1:0] addr_cache;
    logic [AXI_ADDR_WIDTH-1:0] grant_rf_addr;
    logic [WD_W-1:0]           wdog;
    logic                      err_flag;
    logic                      set_err;
    logic                      wd_expire;
    logic                      grant_valid;
    t_req_id                   grant_id;

    ysyx_201979054_rr_arbiter u_arb (
        .clk         (clk),
        .arst        (arst),
        .req_i       (i_req_i),
        .req_d       (i_req_d),
        .grant_done  (state == RESP),
        .done_id     (owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign grant_rf_addr = (grant_id == REQ_I) ? i_addr_i : i_addr_d;
    assign wd_expire     = (wdog == WD_LAST) && !i_count_done;

    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    next_state = (grant_id == REQ_D && i_dirty_d) ? WB_START : RF_START;
                end
            end
            WB_START: next_state = WB_RUN;
            WB_RUN: begin
                // An error here skips the refill entirely.
                if (i_axi_error || wd_expire) begin
                    next_state = RESP;
                    set_err    = 1'b1;
                end else if (i_count_done) begin
                    next_state = RF_START;
                end
            end
            RF_START: next_state = RF_RUN;
            RF_RUN: begin
                if (i_axi_error || wd_expire) begin
                    next_state = RESP;
                    set_err    = 1'b1;
                end else if (i_count_done) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state      <= IDLE;
            owner      <= REQ_I;
            rf_addr    <= '0;
            addr_cache <= '0;
            wdog       <= '0;
            err_flag   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && grant_valid) begin
                owner    <= grant_id;
                rf_addr  <= grant_rf_addr;
                err_flag <= 1'b0;
                addr_cache <= (next_state == WB_START) ? (i_wb_addr_d & ALIGN_MASK)
                                                       : (grant_rf_addr & ALIGN_MASK);
            end
            if (state == WB_RUN && next_state == RF_START) begin
                addr_cache <= rf_addr & ALIGN_MASK;
            end
            if (set_err) begin
                err_flag <= 1'b1;
            end
            if (state == WB_START || state == RF_START) begin
                wdog <= '0;
            end else if (state == WB_RUN || state == RF_RUN) begin
                wdog <= wdog + WD_W'(1);
            end
        end
    end

    assign o_start_write = (state == WB_START);
    assign o_start_read  = (state == RF_START);
    assign o_wr_active   = (state == WB_RUN);
    assign o_rd_active   = (state == RF_RUN);
    assign o_addr_cache  = addr_cache;
    assign o_busy        = (state != IDLE);
    assign o_grant_i     = o_busy && (owner == REQ_I);
    assign o_grant_d     = o_busy && (owner == REQ_D);
    assign o_done_i      = (state == RESP) && (owner == REQ_I);
    assign o_done_d      = (state == RESP) && (owner == REQ_D);
    assign o_error       = (state == RESP) && err_flag;

endmodule

// File: tb/tb_ysyx_201979054_cache_xfer_ctrl.sv
// Scoreboard bench for the cache transfer controller: expected start/done events are
// queued when a request is driven and popped by a monitor as the DUT produces them.
module tb_ysyx_201979054_cache_xfer_ctrl;

    localparam logic [63:0] MASK = ~64'h3F;

    typedef struct {
        int          kind;
        logic [63:0] addr;
        logic        err;
    } exp_t;

    localparam int EV_WR = 0;
    localparam int EV_RD = 1;
    localparam int EV_DI = 2;
    localparam int EV_DD = 3;

    logic        clk;
    logic        arst;
    logic        i_req_i;
    logic [63:0] i_addr_i;
    logic        i_req_d;
    logic        i_dirty_d;
    logic [63:0] i_addr_d;
    logic [63:0] i_wb_addr_d;
    logic        i_count_done;
    logic        i_axi_error;
    logic        o_start_read;
    logic        o_start_write;
    logic        o_rd_active;
    logic        o_wr_active;
    logic [63:0] o_addr_cache;
    logic        o_grant_i;
    logic        o_grant_d;
    logic        o_done_i;
    logic        o_done_d;
    logic        o_error;
    logic        o_busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   last_d;
    exp_t sb[$];
    exp_t mon_e;
    logic [3:0] mon_ev;

    ysyx_201979054_cache_xfer_ctrl #(
        .AXI_ADDR_WIDTH (64),
        .OFFSET_BITS    (6),
        .TIMEOUT        (16)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .i_req_i       (i_req_i),
        .i_addr_i      (i_addr_i),
        .i_req_d       (i_req_d),
        .i_dirty_d     (i_dirty_d),
        .i_addr_d      (i_addr_d),
        .i_wb_addr_d   (i_wb_addr_d),
        .i_count_done  (i_count_done),
        .i_axi_error   (i_axi_error),
        .o_start_read  (o_start_read),
        .o_start_write (o_start_write),
        .o_rd_active   (o_rd_active),
        .o_wr_active   (o_wr_active),
        .o_addr_cache  (o_addr_cache),
        .o_grant_i     (o_grant_i),
        .o_grant_d     (o_grant_d),
        .o_done_i      (o_done_i),
        .o_done_d      (o_done_d),
        .o_error       (o_error),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Any start or done pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!arst) begin
            mon_ev = {o_done_d, o_done_i, o_start_read, o_start_write};
            for (int k = 0; k < 4; k++) begin
                if (mon_ev[k]) begin
                    if (sb.size() == 0) begin
                        checkOutput("sb_unexpected", 64'(k), 64'd99);
                    end else begin
                        mon_e = sb.pop_front();
                        checkOutput("evt_kind", 64'(k), 64'(mon_e.kind));
                        if (k < 2) checkOutput("evt_addr", o_addr_cache, mon_e.addr);
                        else       checkOutput("evt_err", 64'(o_error), 64'(mon_e.err));
                    end
                end
            end
        end
    end

    // mode: 0 clean, 1 AXI error (with count_done) in first run phase, 2 watchdog timeout.
    task automatic applyStimulus(input bit ri, input bit rd, input bit dirty,
                                 input logic [63:0] ai, input logic [63:0] ad,
                                 input logic [63:0] wb, input int mode);
        bit   win_d;
        bit   do_wb;
        int   phases;
        int   t_start;
        bit   seen;
        logic [1:0] gexp;
        win_d  = (ri && rd) ? !last_d : rd;
        do_wb  = win_d && dirty;
        gexp   = win_d ? 2'b01 : 2'b10;
        phases = (do_wb && mode == 0) ? 2 : 1;
        if (do_wb) sb.push_back('{EV_WR, wb & MASK, 1'b0});
        if (!(do_wb && mode != 0)) sb.push_back('{EV_RD, (win_d ? ad : ai) & MASK, 1'b0});
        sb.push_back('{win_d ? EV_DD : EV_DI, 64'd0, mode != 0});
        last_d = win_d;

        i_req_i = ri; i_req_d = rd; i_dirty_d = dirty;
        i_addr_i = ai; i_addr_d = ad; i_wb_addr_d = wb;
        @(negedge clk);
        checkOutput("start_lat", {62'd0, o_start_write, o_start_read}, do_wb ? 64'd2 : 64'd1);
        checkOutput("grant", {62'd0, o_grant_i, o_grant_d}, 64'(gexp));
        t_start = cyc;
        for (int p = 0; p < phases; p++) begin
            @(negedge clk);
            if (mode == 2) break;
            repeat (2) @(negedge clk);
            i_count_done = 1'b1;
            if (mode == 1) i_axi_error = 1'b1;
            @(negedge clk);
            i_count_done = 1'b0;
            i_axi_error  = 1'b0;
            if (p + 1 < phases) begin
                checkOutput("rf_after_wb", 64'(o_start_read), 64'd1);
                checkOutput("grant_mid", {62'd0, o_grant_i, o_grant_d}, 64'(gexp));
            end
        end
        if (mode == 2) begin
            seen = 1'b0;
            for (int w = 0; w < 40 && !seen; w++) begin
                @(negedge clk);
                seen = o_done_i | o_done_d;
            end
            checkOutput("to_seen", 64'(seen), 64'd1);
            checkOutput("to_lat", 64'(cyc - t_start), 64'd17);
        end else begin
            checkOutput("done_lat", {62'd0, o_done_i, o_done_d}, 64'(gexp));
        end
        checkOutput("grant_resp", {62'd0, o_grant_i, o_grant_d}, 64'(gexp));
        i_req_i = 1'b0;
        i_req_d = 1'b0;
        @(negedge clk);
        checkOutput("idle_after", {62'd0, o_busy, o_grant_i | o_grant_d}, 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {54'd0, o_start_read, o_start_write, o_rd_active, o_wr_active,
                          o_grant_i, o_grant_d, o_done_i, o_done_d, o_error, o_busy}, 64'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] hung");
    end

    initial begin
        arst = 1'b1;
        i_req_i = 0; i_req_d = 0; i_dirty_d = 0;
        i_addr_i = 0; i_addr_d = 0; i_wb_addr_d = 0;
        i_count_done = 0; i_axi_error = 0;
        last_d = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("reset_outs");
        checkOutput("reset_addr", o_addr_cache, 64'd0);
        arst = 1'b0;
        @(negedge clk);

        $display("[TB] contention: ties alternate I, D, I, D");
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1, 1, 0, 64'h8000_2000 + 64'(n * 'h47), 64'h8000_3000 + 64'(n * 'h81), 64'h0, 0);
        end

        $display("[TB] idle I refill");
        applyStimulus(1, 0, 0, 64'h8000_0047, 64'h0, 64'h0, 0);

        $display("[TB] dirty D writeback then refill");
        applyStimulus(0, 1, 1, 64'h0, 64'h8000_1000, 64'h9000_00C0, 0);

        $display("[TB] AXI error during writeback");
        applyStimulus(0, 1, 1, 64'h0, 64'h8000_1234, 64'h9000_0155, 1);

        $display("[TB] AXI error during refill");
        applyStimulus(1, 0, 0, 64'h8000_07FF, 64'h0, 64'h0, 1);

        $display("[TB] watchdog timeout");
        applyStimulus(1, 0, 0, 64'h8000_4010, 64'h0, 64'h0, 2);

        $display("[TB] reset in the middle of a refill");
        sb.push_back('{EV_RD, 64'h8000_5000, 1'b0});
        i_req_i = 1'b1; i_addr_i = 64'h8000_5033;
        repeat (3) @(negedge clk);
        checkOutput("mid_rd_active", 64'(o_rd_active), 64'd1);
        arst = 1'b1;
        @(negedge clk);
        checkAllZero("mid_reset_outs");
        i_req_i = 1'b0;
        arst = 1'b0;
        last_d = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mid_no_done", 64'(o_busy), 64'd0);
        applyStimulus(1, 1, 0, 64'h8000_6040, 64'h8000_7080, 64'h0, 0);
        applyStimulus(1, 1, 1, 64'h8000_6040, 64'h8000_7080, 64'h9000_8000, 0);

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
